// File: rtl/capture_ctrl.sv
// Trigger-based capture sequencer: fills a dual-port RAM as a circular buffer,
// stops a programmed number of samples after a trigger, then streams the window out.
module capture_ctrl #(
    parameter int unsigned DATAWIDTH = 9,
    parameter int unsigned ADDRWIDTH = 9
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 arm_i,
    input  logic [ADDRWIDTH-1:0] post_count_i,
    input  logic [DATAWIDTH-1:0] sample_data_i,
    input  logic                 sample_valid_i,
    input  logic                 trigger_i,
    input  logic                 rd_start_i,
    output logic [DATAWIDTH-1:0] rd_data_o,
    output logic                 rd_valid_o,
    output logic                 rd_last_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [ADDRWIDTH-1:0] trig_addr_o,
    output logic [ADDRWIDTH:0]   fill_o,
    output logic [DATAWIDTH-1:0] ram_wr_data_o,
    output logic [ADDRWIDTH-1:0] ram_wr_addr_o,
    output logic                 ram_we_o,
    output logic [ADDRWIDTH-1:0] ram_rd_addr_o,
    input  logic [DATAWIDTH-1:0] ram_rd_data_i
);

    localparam logic [ADDRWIDTH:0] FillMax = {1'b1, {ADDRWIDTH{1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StPost,
        StDone,
        StRead
    } state_e;

    state_e               state_q, state_d;
    logic [ADDRWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRWIDTH:0]   fill_q, fill_d;
    logic [ADDRWIDTH-1:0] post_left_q, post_left_d;
    logic [ADDRWIDTH-1:0] trig_addr_q, trig_addr_d;
    logic [ADDRWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRWIDTH:0]   rd_cnt_q, rd_cnt_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 rd_last_q, rd_last_d;
    logic                 wr_en;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        post_left_d = post_left_q;
        trig_addr_d = trig_addr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_cnt_d    = rd_cnt_q;
        rd_valid_d  = 1'b0;
        rd_last_d   = 1'b0;
        wr_en       = 1'b0;

        if (arm_i) begin
            // Restart from any state; the same-cycle sample, trigger and rd_start are dropped.
            state_d     = StArmed;
            wr_ptr_d    = '0;
            fill_d      = '0;
            post_left_d = post_count_i;
            rd_ptr_d    = '0;
            rd_cnt_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StArmed: begin
                    if (sample_valid_i) begin
                        wr_en = 1'b1;
                        if (trigger_i) begin
                            trig_addr_d = wr_ptr_q;
                            state_d     = (post_left_q == '0) ? StDone : StPost;
                        end
                    end
                end
                StPost: begin
                    if (sample_valid_i) begin
                        wr_en       = 1'b1;
                        post_left_d = post_left_q - ADDRWIDTH'(1);
                        if (post_left_q == ADDRWIDTH'(1)) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    if (rd_start_i) begin
                        // Oldest word sits fill entries behind the write pointer.
                        rd_ptr_d = wr_ptr_q - fill_q[ADDRWIDTH-1:0];
                        rd_cnt_d = fill_q;
                        state_d  = StRead;
                    end
                end
                StRead: begin
                    if (rd_cnt_q != '0) begin
                        rd_valid_d = 1'b1;
                        rd_last_d  = (rd_cnt_q == (ADDRWIDTH + 1)'(1));
                        rd_ptr_d   = rd_ptr_q + ADDRWIDTH'(1);
                        rd_cnt_d   = rd_cnt_q - (ADDRWIDTH + 1)'(1);
                    end
                    if (rd_cnt_q <= (ADDRWIDTH + 1)'(1)) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDRWIDTH'(1);
            if (fill_q != FillMax) begin
                fill_d = fill_q + (ADDRWIDTH + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            post_left_q <= '0;
            trig_addr_q <= '0;
            rd_ptr_q    <= '0;
            rd_cnt_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            post_left_q <= post_left_d;
            trig_addr_q <= trig_addr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
        end
    end

    // rd_valid/rd_last trail the issued address by the RAM's one-cycle read latency.
    assign rd_data_o     = ram_rd_data_i;
    assign rd_valid_o    = rd_valid_q;
    assign rd_last_o     = rd_last_q;
    assign busy_o        = (state_q == StArmed) || (state_q == StPost);
    assign done_o        = (state_q == StDone);
    assign trig_addr_o   = trig_addr_q;
    assign fill_o        = fill_q;
    assign ram_we_o      = wr_en;
    assign ram_wr_addr_o = wr_ptr_q;
    assign ram_wr_data_o = wr_en ? sample_data_i : '0;
    assign ram_rd_addr_o = rd_ptr_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: a queue-based model of the capture window checked every cycle,
// plus directed scenarios with literal expectations.
module tb_capture_ctrl;

    localparam int DW = 9;
    localparam int AW = 9;
    localparam int D  = 512;

    localparam int MIdle  = 0;
    localparam int MArmed = 1;
    localparam int MPost  = 2;
    localparam int MDone  = 3;
    localparam int MRead  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          arm = 1'b0;
    logic [AW-1:0] post_count = '0;
    logic [DW-1:0] sample_data = '0;
    logic          sample_valid = 1'b0;
    logic          trigger = 1'b0;
    logic          rd_start = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_last, busy, done;
    logic [AW-1:0] trig_addr;
    logic [AW:0]   fill;
    logic [DW-1:0] ram_wr_data;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic          ram_we;
    logic [DW-1:0] ram_rd_data;
    logic [DW-1:0] mem [D];

    int n_checks = 0;
    int n_fail = 0;

    capture_ctrl #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .arm_i          (arm),
        .post_count_i   (post_count),
        .sample_data_i  (sample_data),
        .sample_valid_i (sample_valid),
        .trigger_i      (trigger),
        .rd_start_i     (rd_start),
        .rd_data_o      (rd_data),
        .rd_valid_o     (rd_valid),
        .rd_last_o      (rd_last),
        .busy_o         (busy),
        .done_o         (done),
        .trig_addr_o    (trig_addr),
        .fill_o         (fill),
        .ram_wr_data_o  (ram_wr_data),
        .ram_wr_addr_o  (ram_wr_addr),
        .ram_we_o       (ram_we),
        .ram_rd_addr_o  (ram_rd_addr),
        .ram_rd_data_i  (ram_rd_data)
    );

    always #5 clk = ~clk;

    // Dual-port RAM with registered read.
    always @(posedge clk) begin
        if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_rd_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the window is simply the last D samples written since arm.
    int            m_mode = MIdle;
    logic [DW-1:0] hist[$];
    int            m_total = 0;
    int            m_post = 0;
    int            m_trig = 0;
    logic [DW-1:0] m_words[$];
    logic          m_valid = 1'b0;
    logic          m_last = 1'b0;
    logic [DW-1:0] m_data = '0;

    function automatic void m_write(input logic [DW-1:0] v);
        hist.push_back(v);
        if (hist.size() > D) void'(hist.pop_front());
        m_total++;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = MIdle; hist.delete(); m_total = 0; m_post = 0; m_trig = 0;
            m_words.delete(); m_valid = 1'b0; m_last = 1'b0;
        end else begin
            m_valid = 1'b0;
            m_last = 1'b0;
            if (arm) begin
                m_mode = MArmed; hist.delete(); m_total = 0; m_post = int'(post_count);
            end else begin
                case (m_mode)
                    MArmed: if (sample_valid) begin
                        if (trigger) begin
                            m_trig = m_total % D;
                            m_mode = (m_post == 0) ? MDone : MPost;
                        end
                        m_write(sample_data);
                    end
                    MPost: if (sample_valid) begin
                        m_write(sample_data);
                        m_post--;
                        if (m_post == 0) m_mode = MDone;
                    end
                    MDone: if (rd_start) begin
                        m_words = hist;
                        m_mode = MRead;
                    end
                    MRead: begin
                        if (m_words.size() > 0) begin
                            m_data = m_words.pop_front();
                            m_valid = 1'b1;
                            m_last = (m_words.size() == 0);
                        end
                        if (m_words.size() == 0) m_mode = MIdle;
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [DW-1:0] got[$];
    int            last_cnt = 0;
    int            last_word = -1;

    always @(negedge clk) begin
        logic exp_we;
        exp_we = (m_mode == MArmed || m_mode == MPost) && sample_valid && !arm;
        check("ram_we", ram_we, exp_we);
        if (exp_we) check("ram_wr_data", ram_wr_data, sample_data);
        check("ram_wr_addr", ram_wr_addr, m_total % D);
        check("busy", busy, (m_mode == MArmed || m_mode == MPost));
        check("done", done, (m_mode == MDone));
        check("fill", fill, hist.size());
        check("trig_addr", trig_addr, m_trig);
        check("rd_valid", rd_valid, m_valid);
        check("rd_last", rd_last, m_last);
        if (m_valid) check("rd_data", rd_data, m_data);
        if (rd_valid) got.push_back(rd_data);
        if (rd_last) begin
            last_cnt++;
            last_word = rd_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input int pc);
        arm = 1'b1;
        post_count = pc[AW-1:0];
        tick();
        arm = 1'b0;
    endtask

    task automatic stream(input int first, input int last, input int trig_val);
        for (int v = first; v <= last; v++) begin
            sample_valid = 1'b1;
            sample_data = v[DW-1:0];
            trigger = (v == trig_val);
            tick();
        end
        sample_valid = 1'b0;
        trigger = 1'b0;
    endtask

    task automatic readout(input int cycles);
        got.delete();
        last_cnt = 0;
        last_word = -1;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        repeat (cycles) tick();
    endtask

    logic vv[9] = '{1, 0, 1, 1, 0, 1, 0, 1, 1};
    logic tt[9] = '{0, 1, 0, 1, 0, 0, 1, 0, 0};

    initial begin
        #2;
        check("rst rd_valid", rd_valid, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst fill", fill, 0);
        check("rst ram_rd_addr", ram_rd_addr, 0);
        #10 reset = 1'b0;
        tick();

        // Basic capture and readout.
        do_arm(3);
        stream(0, 110, 100);
        check("basic trig_addr", trig_addr, 100);
        check("basic fill", fill, 104);
        readout(107);
        check("basic count", got.size(), 104);
        check("basic first", got[0], 0);
        check("basic last", last_word, 103);
        check("basic last_cnt", last_cnt, 1);

        // Zero post-trigger samples.
        do_arm(0);
        sample_valid = 1'b1; sample_data = 9'd7; trigger = 1'b1;
        tick();
        sample_valid = 1'b0; trigger = 1'b0;
        check("zero done", done, 1);
        check("zero fill", fill, 1);
        readout(4);
        check("zero count", got.size(), 1);
        check("zero word", last_word, 7);

        // arm with trigger in IDLE, then gapped input.
        arm = 1'b1; post_count = 9'd2; trigger = 1'b1; sample_valid = 1'b1; sample_data = 9'd5;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 9; i++) begin
            sample_valid = vv[i];
            trigger = tt[i];
            sample_data = DW'(10 + i);
            tick();
        end
        sample_valid = 1'b0; trigger = 1'b0;
        check("gap fill", fill, 5);
        check("gap trig_addr", trig_addr, 2);
        readout(8);
        check("gap count", got.size(), 5);
        check("gap w2", got[2], 13);
        check("gap w4", got[4], 17);

        // Abort during POST, then during READ.
        do_arm(5);
        stream(0, 21, 20);
        arm = 1'b1; post_count = 9'd1; sample_valid = 1'b1; sample_data = 9'd99;
        tick();
        arm = 1'b0; sample_valid = 1'b0;
        check("abort fill", fill, 0);
        check("abort wr_addr", ram_wr_addr, 0);
        stream(40, 60, 45);
        check("abort2 fill", fill, 7);
        check("abort2 trig_addr", trig_addr, 5);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick(); tick();
        check("read midway", rd_valid, 1);
        do_arm(0);
        check("read abort", rd_valid, 0);
        stream(200, 219, 200);

        // Async reset mid-readout.
        do_arm(9);
        stream(300, 319, 305);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick(); tick();
        #3 reset = 1'b1;
        #1;
        check("areset rd_valid", rd_valid, 0);
        check("areset fill", fill, 0);
        check("areset trig", trig_addr, 0);
        check("areset rd_addr", ram_rd_addr, 0);
        check("areset we", ram_we, 0);
        #2 reset = 1'b0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        repeat (4) tick();
        check("post-reset done", done, 0);

        // Wrap-around.
        do_arm(10);
        stream(0, 1020, 1000);
        check("wrap fill", fill, 512);
        check("wrap trig_addr", trig_addr, 488);
        readout(515);
        check("wrap count", got.size(), 512);
        check("wrap first", got[0], 499);
        check("wrap last", last_word, 1010 % 512);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Trigger-based capture sequencer for one dual-port inferred RAM (DATAWIDTH x 2^ADDRWIDTH, registered read, one-cycle read latency). Once armed, it writes a sample stream into the RAM as a circular buffer. On a trigger it captures a programmed number of post-trigger samples, then stops. A host-side request then streams out the captured window oldest-first. It sits between the capture/inject datapath and the RAM, and is the only master of both RAM ports.

## Interface
- DATAWIDTH, 9, sample and RAM word width
- ADDRWIDTH, 9, RAM address width; depth D = 2^ADDRWIDTH
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- arm  in  1  pulse: start a new capture (latches post_count)
- post_count  in  ADDRWIDTH  samples to keep after the trigger sample
- sample_data  in  DATAWIDTH  sample stream
- sample_valid  in  1  sample_data qualifier
- trigger  in  1  trigger; honoured only together with sample_valid
- rd_start  in  1  pulse: begin readout (honoured only in DONE)
- rd_data  out  DATAWIDTH  readout word, driven combinationally from ram_rd_data
- rd_valid  out  1  rd_data valid
- rd_last  out  1  final readout word (asserted only with rd_valid)
- busy  out  1  state is ARMED or POST
- done  out  1  state is DONE
- trig_addr  out  ADDRWIDTH  RAM address holding the trigger sample
- fill  out  ADDRWIDTH+1  captured word count, saturates at D
- ram_wr_data  out  DATAWIDTH, ram_wr_addr  out  ADDRWIDTH, ram_we  out  1  RAM write port
- ram_rd_addr  out  ADDRWIDTH, ram_rd_data  in  DATAWIDTH  RAM read port

## Operation
- States: IDLE, ARMED, POST, DONE, READ.
- IDLE: no writes. arm -> ARMED. At arm: wr_ptr=0, fill=0, post_left=post_count.
- ARMED: each sample_valid writes sample_data at wr_ptr (ram_we=1), wr_ptr+1 mod D, fill+1 saturating at D. A valid sample with trigger high is the trigger sample: trig_addr=wr_ptr. If post_left==0 -> DONE, else -> POST.
- POST: each valid sample is written as in ARMED and decrements post_left. The write that takes post_left from 1 to 0 -> DONE. trigger is ignored.
- DONE: no writes, contents frozen. rd_start -> READ. rd_ptr = (wr_ptr - fill) mod D, i.e. the oldest word. rd_cnt = fill.
- READ: each cycle issue ram_rd_addr=rd_ptr, rd_ptr+1, rd_cnt-1 until fill addresses have been issued. Then -> IDLE with done low and fill retained.
- rd_valid is the one-cycle-delayed "address issued" flag. rd_last is the delayed "final address" flag.
- If fill==0 at rd_start: READ issues nothing and returns to IDLE next cycle; rd_valid never asserts.
- arm in any state other than IDLE aborts the current activity and restarts ARMED with fresh pointers. An aborted readout drops rd_valid the next cycle.
- arm has priority over trigger, sample_valid and rd_start in the same cycle. In that cycle the sample is not written.
- arm and trigger together in IDLE: arm only; the trigger is lost.
- rd_start outside DONE is ignored. trigger without sample_valid is ignored.
- Wrap-around: the ARMED phase may overwrite indefinitely. Once fill==D, readout always returns D words starting at wr_ptr.
- post_count >= D-1 is legal. The trigger sample may be overwritten if more than D-1 post samples are captured; trig_addr still reports where it was written.

## Timing
- Reset values: state IDLE. rd_valid, rd_last, busy, done, ram_we = 0. trig_addr, fill, ram_wr_addr, ram_rd_addr, ram_wr_data = 0.
- Async reset mid-capture or mid-readout forces IDLE immediately. RAM contents are untouched.
- Write path is combinational from the inputs: ram_we = sample_valid in ARMED/POST with no arm; ram_wr_data=sample_data; ram_wr_addr=wr_ptr.
- DONE is entered at the edge that performs the last write. done is high the following cycle.
- Readout latency:
  - rd_start sampled at edge T loads rd_ptr.
  - The first address is presented after T.
  - The RAM registers the word at T+1.
  - rd_valid is high in the cycle after T+1.
  - Words then stream one per cycle with no gaps.
  - rd_last coincides with word fill-1.
- Throughput: one sample per cycle while capturing; one word per cycle on readout.

## Test plan
- Basic: D=512, post_count=3, arm, stream 0,1,2..., trigger on value 100 -> writes stop after 103, trig_addr=100, fill=104. Readout yields 0..103 with rd_last on 103.
- Wrap: post_count=10, trigger on value 1000 -> fill=512, readout 499..1010 in order, trig_addr=1000 mod 512=488.
- Zero post: post_count=0, trigger on first valid sample -> done next cycle, fill=1, single word with rd_valid and rd_last together.
- Gapped input: sample_valid toggling, trigger without sample_valid ignored; post samples are counted only on valid cycles.
- Abort: arm during POST and during READ -> immediate restart; rd_valid low within one cycle; new capture starts at address 0.
- Reset mid-READ: assert reset asynchronously -> all outputs at reset values with no clock edge; rd_start afterwards is ignored until a fresh capture completes.
